// File: rtl/edge_event_if.sv
// Bundles the channel inputs and status outputs of edge_event_unit.
// The master side drives inputs and clears. The slave side is the detector itself.
interface edge_event_if #(
   parameter int CH    = 4,
   parameter int CNT_W = 8
);
   logic [CH-1:0]       a;
   logic [2*CH-1:0]     mode;
   logic [CH-1:0]       pend_clr;
   logic [CH-1:0]       cnt_clr;
   logic [CH-1:0]       rise;
   logic [CH-1:0]       down;
   logic [CH-1:0]       level;
   logic [CH-1:0]       pend;
   logic [CH*CNT_W-1:0] cnt;
   logic                irq;

   modport master (
      output a, mode, pend_clr, cnt_clr,
      input  rise, down, level, pend, cnt, irq
   );

   modport slave (
      input  a, mode, pend_clr, cnt_clr,
      output rise, down, level, pend, cnt, irq
   );
endinterface

// File: rtl/edge_event_unit.sv
// Multi-channel edge detector: synchroniser, glitch filter, edge pulses,
// sticky W1C pending flags, saturating event counters and an OR'd interrupt.
module edge_event_unit #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3,
   parameter int CNT_W       = 8
) (
   input logic         clk,
   input logic         rst_n,
   edge_event_if.slave bus
);
   localparam int                FCNT_W    = $clog2(FILT_LEN + 1);
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [SYNC_STAGES-1:0] sync_r [CH];
   logic [FCNT_W-1:0]      fcnt_r [CH];
   logic [CNT_W-1:0]       cnt_r  [CH];
   logic [CH-1:0]          level_r;
   logic [CH-1:0]          rise_r;
   logic [CH-1:0]          down_r;
   logic [CH-1:0]          pend_r;

   logic [FCNT_W-1:0]      fcnt_next_s [CH];
   logic [CNT_W-1:0]       cnt_next_s  [CH];
   logic [CH-1:0]          s_s;
   logic [CH-1:0]          next_level_s;
   logic [CH-1:0]          rise_next_s;
   logic [CH-1:0]          down_next_s;
   logic [CH-1:0]          ev_s;
   logic [CH*CNT_W-1:0]    cnt_flat_s;

   // Per-channel filter, edge detection, event select and counter next-state
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         s_s[i]          = sync_r[i][SYNC_STAGES-1];
         next_level_s[i] = level_r[i];
         fcnt_next_s[i]  = '0;
         if (s_s[i] != level_r[i]) begin
            if (fcnt_r[i] == FCNT_LAST) begin
               next_level_s[i] = s_s[i];
               fcnt_next_s[i]  = '0;
            end else begin
               fcnt_next_s[i]  = fcnt_r[i] + FCNT_W'(1);
            end
         end else begin
            fcnt_next_s[i] = '0;
         end
         rise_next_s[i] = next_level_s[i] & ~level_r[i];
         down_next_s[i] = ~next_level_s[i] & level_r[i];
         ev_s[i] = (rise_next_s[i] & bus.mode[2*i]) | (down_next_s[i] & bus.mode[2*i+1]);
         // A clear coinciding with an event leaves the new event counted
         if (bus.cnt_clr[i]) begin
            cnt_next_s[i] = ev_s[i] ? CNT_W'(1) : '0;
         end else if (ev_s[i] && (cnt_r[i] != CNT_MAX)) begin
            cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
         end else begin
            cnt_next_s[i] = cnt_r[i];
         end
      end
   end

   // Pack the per-channel counters onto the flat output bus
   always_comb begin
      cnt_flat_s = '0;
      for (int i = 0; i < CH; i++) begin
         cnt_flat_s[CNT_W*i +: CNT_W] = cnt_r[i];
      end
   end

   // All channel state; set wins over the same-cycle pend_clr
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            sync_r[i] <= '0;
            fcnt_r[i] <= '0;
            cnt_r[i]  <= '0;
         end
         level_r <= '0;
         rise_r  <= '0;
         down_r  <= '0;
         pend_r  <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], bus.a[i]};
            fcnt_r[i] <= fcnt_next_s[i];
            cnt_r[i]  <= cnt_next_s[i];
         end
         level_r <= next_level_s;
         rise_r  <= rise_next_s;
         down_r  <= down_next_s;
         pend_r  <= (pend_r & ~bus.pend_clr) | ev_s;
      end
   end

   assign bus.rise  = rise_r;
   assign bus.down  = down_r;
   assign bus.level = level_r;
   assign bus.pend  = pend_r;
   assign bus.cnt   = cnt_flat_s;
   assign bus.irq   = |pend_r;
endmodule

// File: tb/tb_edge_event_unit.sv
// Bench for edge_event_unit: expected rise/down pulses are queued with their due
// cycle when an input is driven and matched against the DUT pulses as they appear.
module tb_edge_event_unit;
   localparam int LAT = 5;

   typedef struct {
      int ch;
      int kind;
      int cyc;
   } pulse_t;

   logic   clk = 1'b0;
   logic   rst_n;
   int     cyc;
   int     n_checks = 0;
   int     n_fail = 0;
   pulse_t exp_q[$];

   edge_event_if #(.CH(4), .CNT_W(8)) dut_if ();
   edge_event_if #(.CH(4), .CNT_W(2)) sat_if ();

   edge_event_unit #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(dut_if)
   );

   edge_event_unit #(.CH(4), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .bus(sat_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Drive a main-DUT channel; a real change queues the pulse due LAT edges later
   task automatic set_a(input int ch, input logic v);
      if (dut_if.a[ch] !== v) exp_q.push_back('{ch, v ? 0 : 1, cyc + LAT});
      dut_if.a[ch] = v;
   endtask

   // One clock: sample pulses at the falling edge, score them, return just after the rising edge
   task automatic step();
      pulse_t e;
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL pulse_missing: ch%0d kind %0d got no pulse by cycle %0d, required at cycle %0d",
                  e.ch, e.kind, cyc, e.cyc);
      end
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 2; k++) begin
            logic p;
            p = (k == 0) ? dut_if.rise[i] : dut_if.down[i];
            if (p === 1'b1) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL pulse_unexpected: got ch%0d kind %0d at cycle %0d, required none", i, k, cyc);
               end else begin
                  e = exp_q.pop_front();
                  if (e.ch != i || e.kind != k || e.cyc != cyc) begin
                     n_fail++;
                     $display("FAIL pulse_match: got ch%0d kind %0d cycle %0d, required ch%0d kind %0d cycle %0d",
                              i, k, cyc, e.ch, e.kind, e.cyc);
                  end
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({dut_if.level, dut_if.rise, dut_if.down, dut_if.pend, dut_if.cnt, dut_if.irq} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got level %h pend %h cnt %h irq %b, required all zero",
                  dut_if.level, dut_if.pend, dut_if.cnt, dut_if.irq);
      end
      rst_n = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_latency();
      dut_if.mode = 8'b00_00_00_01;
      set_a(0, 1'b1);
      repeat (4) step();
      n_checks++;
      if (dut_if.level[0] !== 1'b0) begin
         n_fail++; $display("FAIL lat_level_early: got %b, required 0", dut_if.level[0]);
      end
      step();
      n_checks++;
      if ({dut_if.level[0], dut_if.rise[0], dut_if.pend[0], dut_if.irq} !== 4'b1111) begin
         n_fail++; $display("FAIL lat_edge5: got level/rise/pend/irq %b%b%b%b, required 1111",
                            dut_if.level[0], dut_if.rise[0], dut_if.pend[0], dut_if.irq);
      end
      n_checks++;
      if (dut_if.cnt[7:0] !== 8'd1) begin
         n_fail++; $display("FAIL lat_cnt0: got %0d, required 1", dut_if.cnt[7:0]);
      end
      step();
      set_a(0, 1'b0);
      repeat (8) step();
      n_checks++;
      if (dut_if.cnt[7:0] !== 8'd1 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL lat_fall_ignored: got cnt0 %0d pending %0d, required 1 and 0",
                            dut_if.cnt[7:0], exp_q.size());
      end
   endtask

   task automatic test_glitch();
      dut_if.mode = 8'b00_00_11_01;
      dut_if.a[1] = 1'b1;
      repeat (2) step();
      dut_if.a[1] = 1'b0;
      repeat (8) step();
      n_checks++;
      if ({dut_if.level[1], dut_if.pend[1], dut_if.cnt[15:8]} !== 10'd0) begin
         n_fail++; $display("FAIL glitch_2cyc: got level %b pend %b cnt1 %0d, required 0 0 0",
                            dut_if.level[1], dut_if.pend[1], dut_if.cnt[15:8]);
      end
      set_a(1, 1'b1);
      repeat (3) step();
      set_a(1, 1'b0);
      repeat (10) step();
      n_checks++;
      if (dut_if.pend[1] !== 1'b1 || dut_if.cnt[15:8] !== 8'd2 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL glitch_3cyc: got pend %b cnt1 %0d pending %0d, required 1 2 0",
                            dut_if.pend[1], dut_if.cnt[15:8], exp_q.size());
      end
   endtask

   task automatic test_modes();
      logic [1:0] m_tab[3];
      int         mid_tab[3];
      int         end_tab[3];
      m_tab   = '{2'b10, 2'b11, 2'b00};
      mid_tab = '{0, 1, 0};
      end_tab = '{4, 8, 0};
      for (int r = 0; r < 3; r++) begin
         dut_if.pend_clr = 4'hF;
         dut_if.cnt_clr  = 4'b0100;
         step();
         dut_if.pend_clr = 4'h0;
         dut_if.cnt_clr  = 4'h0;
         dut_if.mode[5:4] = m_tab[r];
         for (int t = 0; t < 8; t++) begin
            set_a(2, (t % 2 == 0) ? 1'b1 : 1'b0);
            repeat (4) step();
            if (t == 1) begin
               n_checks++;
               if (dut_if.cnt[23:16] !== 8'(mid_tab[r])) begin
                  n_fail++; $display("FAIL mode_mid m=%b: got cnt2 %0d, required %0d",
                                     m_tab[r], dut_if.cnt[23:16], mid_tab[r]);
               end
            end
         end
         repeat (8) step();
         n_checks++;
         if (dut_if.cnt[23:16] !== 8'(end_tab[r]) || dut_if.pend[2] !== (end_tab[r] != 0)) begin
            n_fail++; $display("FAIL mode_end m=%b: got cnt2 %0d pend %b, required %0d %b",
                               m_tab[r], dut_if.cnt[23:16], dut_if.pend[2], end_tab[r], end_tab[r] != 0);
         end
         n_checks++;
         if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL mode_pulses m=%b: got %0d pulses outstanding, required 0", m_tab[r], exp_q.size());
         end
      end
   endtask

   task automatic test_saturation();
      sat_if.mode = 8'b01_00_00_00;
      for (int n = 0; n < 5; n++) begin
         sat_if.a[3] = 1'b1;
         repeat (4) step();
         sat_if.a[3] = 1'b0;
         repeat (4) step();
      end
      repeat (6) step();
      n_checks++;
      if (sat_if.cnt[7:6] !== 2'd3 || sat_if.pend[3] !== 1'b1) begin
         n_fail++; $display("FAIL sat_hold: got cnt3 %0d pend %b, required 3 1", sat_if.cnt[7:6], sat_if.pend[3]);
      end
      sat_if.a[3] = 1'b1;
      repeat (4) step();
      sat_if.cnt_clr[3] = 1'b1;
      step();
      sat_if.cnt_clr[3] = 1'b0;
      n_checks++;
      if (sat_if.cnt[7:6] !== 2'd1 || sat_if.rise[3] !== 1'b1) begin
         n_fail++; $display("FAIL sat_clr_race: got cnt3 %0d rise %b, required 1 1", sat_if.cnt[7:6], sat_if.rise[3]);
      end
      sat_if.a[3] = 1'b0;
      repeat (8) step();
   endtask

   task automatic test_w1c_race();
      dut_if.pend_clr = 4'hF;
      step();
      dut_if.pend_clr = 4'h0;
      n_checks++;
      if (dut_if.pend !== 4'h0 || dut_if.irq !== 1'b0) begin
         n_fail++; $display("FAIL w1c_all: got pend %h irq %b, required 0 0", dut_if.pend, dut_if.irq);
      end
      set_a(0, 1'b1);
      repeat (4) step();
      dut_if.pend_clr[0] = 1'b1;
      step();
      n_checks++;
      if (dut_if.pend[0] !== 1'b1 || dut_if.cnt[7:0] !== 8'd2) begin
         n_fail++; $display("FAIL w1c_race: got pend0 %b cnt0 %0d, required 1 2", dut_if.pend[0], dut_if.cnt[7:0]);
      end
      step();
      dut_if.pend_clr[0] = 1'b0;
      n_checks++;
      if (dut_if.pend[0] !== 1'b0 || dut_if.irq !== 1'b0) begin
         n_fail++; $display("FAIL w1c_clear: got pend0 %b irq %b, required 0 0", dut_if.pend[0], dut_if.irq);
      end
      set_a(0, 1'b0);
      repeat (8) step();
   endtask

   task automatic test_reset_behaviour();
      dut_if.mode = 8'hFF;
      rst_n = 1'b0;
      dut_if.a = 4'hF;
      repeat (3) step();
      n_checks++;
      if ({dut_if.level, dut_if.rise, dut_if.pend, dut_if.cnt, dut_if.irq} !== '0) begin
         n_fail++; $display("FAIL rst_hold: got level %h pend %h cnt %h, required 0 0 0", dut_if.level, dut_if.pend, dut_if.cnt);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back('{i, 0, cyc + LAT});
      repeat (5) step();
      n_checks++;
      if (dut_if.rise !== 4'hF || dut_if.level !== 4'hF || dut_if.pend !== 4'hF || dut_if.irq !== 1'b1) begin
         n_fail++; $display("FAIL rst_release: got rise %h level %h pend %h irq %b, required f f f 1",
                            dut_if.rise, dut_if.level, dut_if.pend, dut_if.irq);
      end
      n_checks++;
      if (dut_if.cnt !== 32'h01010101) begin
         n_fail++; $display("FAIL rst_release_cnt: got %h, required 01010101", dut_if.cnt);
      end
      step();
      dut_if.a = 4'h0;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({dut_if.level, dut_if.rise, dut_if.down, dut_if.pend, dut_if.cnt, dut_if.irq} !== '0) begin
         n_fail++; $display("FAIL rst_async: got level %h pend %h cnt %h irq %b, required all zero",
                            dut_if.level, dut_if.pend, dut_if.cnt, dut_if.irq);
      end
      repeat (2) step();
      rst_n = 1'b1;
      repeat (10) step();
      n_checks++;
      if (dut_if.level !== 4'h0 || dut_if.pend !== 4'h0 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL rst_midfilter: got level %h pend %h pending %0d, required 0 0 0",
                            dut_if.level, dut_if.pend, exp_q.size());
      end
   endtask

   initial begin
      rst_n           = 1'b0;
      dut_if.a        = 4'h0;
      dut_if.mode     = 8'h00;
      dut_if.pend_clr = 4'h0;
      dut_if.cnt_clr  = 4'h0;
      sat_if.a        = 4'h0;
      sat_if.mode     = 8'h00;
      sat_if.pend_clr = 4'h0;
      sat_if.cnt_clr  = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_latency();
      test_glitch();
      test_modes();
      test_saturation();
      test_w1c_race();
      test_reset_behaviour();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
